// File: rtl/macrow_feeder_pkg.sv
// Shared definitions for the macrow4 row feeder.
// Holds the sequencer state encoding and the constants it shares with the MAC row:
// the default tap count, the FP16 data width and the derived flush length.
package macrow_feeder_pkg;

    localparam int unsigned NTAP_DEF      = 4;
    localparam int unsigned FP16_W        = 16;
    // The row's enable-delay pipeline is NTAP+2 deep, so this many idle cycles drain it.
    localparam int unsigned FLUSH_CYC_DEF = NTAP_DEF + 2;

    typedef enum logic [1:0] {
        StIdle,
        StLoadW,
        StStream,
        StFlush
    } feeder_state_t;

endpackage

// File: rtl/macrow_feeder_hs_reg.sv
// Registered output stage for one feeder path (X or W).
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears data and enable)
//   load        - handshake accepted this cycle
//   en_in       - enable pattern to present when a beat is captured
//   data_in     - beat data
//   en_q        - registered enable; zero on any cycle with no captured beat
//   data_q      - registered data; holds the last captured beat
module feeder_hs_reg #(
    parameter int unsigned DW = 16,
    parameter int unsigned EW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [EW-1:0] en_in,
    input  logic [DW-1:0] data_in,
    output logic [EW-1:0] en_q,
    output logic [DW-1:0] data_q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q   <= '0;
            data_q <= '0;
        end else if (load) begin
            en_q   <= en_in;
            data_q <= data_in;
        end else begin
            en_q   <= '0;
        end
    end

endmodule

// File: rtl/macrow_feeder.sv
// Sequencer for one 4-tap FP16 MAC row: loads tap weights over the broadcast W bus with a
// one-hot enW, streams a gapless run of samples on the X bus, then flushes the row pipeline.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start, reload_w            - job start pulse; reload_w=1 loads weights first
//   w_valid/w_ready/w_data     - weight source handshake
//   x_valid/x_ready/x_data/x_last - sample source handshake, x_last marks the final sample
//   enX_o, enW_o, X_o, W_o     - registered drive to the row's enX/enW/X_i/W_i
//   busy, done                 - not idle; one-cycle pulse at the end of the flush
//   underrun                   - sticky: a sample gap occurred mid-stream
//   sample_cnt                 - samples accepted this job, saturating
module macrow_feeder
    import macrow_feeder_pkg::*;
#(
    parameter int unsigned DW        = FP16_W,
    parameter int unsigned NTAP      = NTAP_DEF,
    parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             reload_w,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [DW-1:0]    w_data,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [DW-1:0]    x_data,
    input  logic             x_last,
    output logic             enX_o,
    output logic [NTAP-1:0]  enW_o,
    output logic [DW-1:0]    X_o,
    output logic [DW-1:0]    W_o,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int unsigned KW = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam int unsigned FW = $clog2(FLUSH_CYC + 1);

    feeder_state_t    state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             underrun_q, underrun_d;
    // Set once the first sample is taken, so leading idle cycles are not an underrun.
    logic             seen_q, seen_d;
    logic [NTAP-1:0]  enw_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            k_q        <= '0;
            flush_q    <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            flush_q    <= flush_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            seen_q     <= seen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        flush_d    = flush_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        seen_d     = seen_q;
        w_ready    = 1'b0;
        x_ready    = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d      = '0;
                    underrun_d = 1'b0;
                    seen_d     = 1'b0;
                    k_d        = '0;
                    flush_d    = '0;
                    state_d    = reload_w ? StLoadW : StStream;
                end
            end
            StLoadW: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    if (k_q == KW'(NTAP - 1)) begin
                        k_d     = '0;
                        state_d = StStream;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StStream: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    seen_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (x_last) begin
                        flush_d = '0;
                        state_d = StFlush;
                    end
                end else if (seen_q) begin
                    underrun_d = 1'b1;
                end
            end
            StFlush: begin
                if (flush_q == FW'(FLUSH_CYC - 1)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        enw_dec      = '0;
        enw_dec[k_q] = 1'b1;
    end

    feeder_hs_reg #(
        .DW(DW),
        .EW(1)
    ) u_x_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (x_valid & x_ready),
        .en_in  (1'b1),
        .data_in(x_data),
        .en_q   (enX_o),
        .data_q (X_o)
    );

    feeder_hs_reg #(
        .DW(DW),
        .EW(NTAP)
    ) u_w_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (w_valid & w_ready),
        .en_in  (enw_dec),
        .data_in(w_data),
        .en_q   (enW_o),
        .data_q (W_o)
    );

    assign busy       = (state_q != StIdle);
    assign underrun   = underrun_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_macrow_feeder.sv
// Scoreboard bench for macrow_feeder: expected row beats are queued with their due cycle when
// a beat is offered, and the output monitor pops and compares them as they appear.
module tb_macrow_feeder;

    localparam int unsigned FLUSH_CYC = 6;

    logic        clk = 1'b0;
    logic        reset, start, reload_w;
    logic        w_valid, w_ready, x_valid, x_ready, x_last;
    logic [15:0] w_data, x_data, X_o, W_o;
    logic        enX_o, busy, done, underrun;
    logic [3:0]  enW_o;
    logic [7:0]  sample_cnt;

    macrow_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .reload_w  (reload_w),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .x_last    (x_last),
        .enX_o     (enX_o),
        .enW_o     (enW_o),
        .X_o       (X_o),
        .W_o       (W_o),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [3:0]  en;
        logic [15:0] data;
    } exp_t;

    exp_t        xq[$];
    exp_t        wq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [15:0] last_x;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: every enable pulse must match the head of its scoreboard queue.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done) done_cnt++;
        if (enX_o) begin
            if (xq.size() == 0) begin
                check("x_unexpected", 1, 0);
            end else begin
                e = xq.pop_front();
                check("x_due", cyc, e.due);
                check("x_data", X_o, e.data);
            end
        end
        if (enW_o != 4'b0) begin
            if (wq.size() == 0) begin
                check("w_unexpected", {28'b0, enW_o}, 0);
            end else begin
                e = wq.pop_front();
                check("w_due", cyc, e.due);
                check("w_en", {28'b0, enW_o}, {28'b0, e.en});
                check("w_data", W_o, e.data);
            end
        end
    end

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic rw);
        start    = 1'b1;
        reload_w = rw;
        @(negedge clk);
        check("busy_before_start", busy, 0);
        next_cycle();
        start    = 1'b0;
        reload_w = 1'b0;
    endtask

    task automatic drive_w(input logic [15:0] d, input int idx);
        exp_t e;
        w_valid = 1'b1;
        w_data  = d;
        @(negedge clk);
        check("w_ready_load", w_ready, 1);
        e.due  = cyc + 1;
        e.en   = 4'b0001 << idx;
        e.data = d;
        wq.push_back(e);
        next_cycle();
        w_valid = 1'b0;
    endtask

    task automatic drive_x(input logic [15:0] d, input logic last, input logic w_offered);
        exp_t e;
        x_valid = 1'b1;
        x_data  = d;
        x_last  = last;
        @(negedge clk);
        check("x_ready_stream", x_ready, 1);
        if (w_offered) check("w_ready_stream", w_ready, 0);
        e.due  = cyc + 1;
        e.en   = 4'b0;
        e.data = d;
        xq.push_back(e);
        last_x = d;
        next_cycle();
        x_valid = 1'b0;
        x_last  = 1'b0;
    endtask

    task automatic idle_cycle(input string tag, input logic exp_x_ready, input logic exp_w_ready);
        @(negedge clk);
        check({tag, "_x_ready"}, x_ready, exp_x_ready);
        check({tag, "_w_ready"}, w_ready, exp_w_ready);
        next_cycle();
    endtask

    // Called in the cycle after the final sample is driven: that cycle shows the last sample,
    // then enX_o stays low while the flush runs; done on the FLUSH_CYC-th flush cycle.
    task automatic flush_walk(input int exp_cnt, input logic exp_ur);
        @(negedge clk);
        check("x_ready_after_last", x_ready, 0);
        for (int i = 0; i < int'(FLUSH_CYC); i++) begin
            @(posedge clk);
            @(negedge clk);
            check("flush_enx", enX_o, 0);
            if (i == 0) check("x_hold", X_o, last_x);
            check("flush_done", done, (i == int'(FLUSH_CYC) - 2) ? 1 : 0);
            check("flush_busy", busy, (i == int'(FLUSH_CYC) - 1) ? 0 : 1);
            check("flush_x_ready", x_ready, 0);
        end
        check("sample_cnt", sample_cnt, exp_cnt);
        check("underrun", underrun, exp_ur);
        next_cycle();
    endtask

    initial begin
        logic [15:0] wts[4];
        int          d0;
        wts      = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        reset    = 1'b1;
        start    = 1'b0;
        reload_w = 1'b0;
        w_valid  = 1'b0;
        x_valid  = 1'b0;
        x_last   = 1'b0;
        w_data   = '0;
        x_data   = '0;
        last_x   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_outs", {enX_o, enW_o, done, underrun, w_ready, x_ready}, 0);
        check("rst_data", {X_o, W_o}, 0);
        check("rst_cnt", sample_cnt, 0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Job 1: load four weights back-to-back, then stream five samples.
        start_job(1'b1);
        for (int i = 0; i < 4; i++) drive_w(wts[i], i);
        for (int i = 0; i < 5; i++) drive_x(16'h3C00 + 16'(i) * 16'h0200, i == 4, 1'b0);
        flush_walk(5, 1'b0);

        // Job 2: keep weights, leading idle cycles, weight beats offered but not taken.
        start_job(1'b0);
        w_valid = 1'b1;
        w_data  = 16'h1234;
        idle_cycle("lead0", 1'b1, 1'b0);
        idle_cycle("lead1", 1'b1, 1'b0);
        w_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_x(16'h5000 + 16'(i), i == 2, 1'b1);
            w_valid = 1'b1;
        end
        flush_walk(3, 1'b0);
        w_valid = 1'b0;

        // Job 3: one-cycle gap after sample 2 of 4 sets the sticky underrun.
        start_job(1'b0);
        drive_x(16'h6001, 1'b0, 1'b0);
        drive_x(16'h6002, 1'b0, 1'b0);
        @(negedge clk);
        check("gap_underrun_pre", underrun, 0);
        next_cycle();
        @(negedge clk);
        check("gap_underrun_set", underrun, 1);
        check("gap_bubble", enX_o, 0);
        next_cycle();
        drive_x(16'h6003, 1'b0, 1'b0);
        drive_x(16'h6004, 1'b1, 1'b0);
        flush_walk(4, 1'b1);
        check("underrun_held_idle", underrun, 1);

        // Job 4: the next start clears underrun; reset after three samples abandons the job.
        start_job(1'b0);
        @(negedge clk);
        check("underrun_cleared", underrun, 0);
        next_cycle();
        for (int i = 0; i < 3; i++) drive_x(16'h7000 + 16'(i), 1'b0, 1'b0);
        d0    = done_cnt;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_enx", enX_o, 0);
        check("mid_rst_enw", enW_o, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", sample_cnt, 0);
        check("mid_rst_x", X_o, 0);
        next_cycle();
        repeat (8) next_cycle();
        check("mid_rst_no_done", done_cnt, d0);

        // Job 5: single-sample job with a start pulsed while busy.
        start_job(1'b0);
        d0    = done_cnt;
        start = 1'b1;
        drive_x(16'h3E00, 1'b1, 1'b0);
        start = 1'b0;
        flush_walk(1, 1'b0);
        idle_cycle("post_single", 1'b0, 1'b0);
        check("single_done_once", done_cnt, d0 + 1);
        @(negedge clk);
        check("second_start_ignored", busy, 0);
        next_cycle();

        // Job 6: reload with a w_valid gap that only stalls the tap index.
        start_job(1'b1);
        drive_w(16'hAA00, 0);
        idle_cycle("w_gap", 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) drive_w(16'hAA00 + 16'(i), i);
        drive_x(16'h4800, 1'b1, 1'b0);
        flush_walk(1, 1'b0);

        repeat (3) next_cycle();
        check("xq_empty", xq.size(), 0);
        check("wq_empty", wq.size(), 0);
        check("total_done", done_cnt, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
